fft_output_reorder: RTL

Output end of the radix-4 16-point FFT pipeline. It takes the four parallel complex lanes that the last butterfly stage emits per group in digit-reversed order, and buffers each 16-bin frame in a ping-pong store. It then streams the frame out serially, one complex bin per beat, in natural bin order 0..15, under a valid/ready handshake. It is the counterpart of the front-end serial-to-parallel selector: that block fans one serial stream into four lanes, and this block collapses four lanes back to one stream.

---
 rtl/fft_output_reorder_if.sv | 48 ++++
 rtl/fft_output_reorder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder_if.sv
// fft_output_reorder_if
//   Bundles the four-lane group input, the serial bin output and the sticky
//   overflow flag of the FFT output reorder block.
//   Handshake: an input group is taken on every rising clock edge where
//   in_valid=1 (there is no input backpressure; a group that cannot be stored
//   is dropped and flagged). An output beat transfers on every rising edge
//   where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0 the
//   output payload holds stable.
//   Modports:
//     slave  - the reorder block (consumes groups, produces bins)
//     master - the environment (produces groups, consumes bins)
interface fft_output_reorder_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_real_0;
  logic [DATA_W-1:0] in_real_1;
  logic [DATA_W-1:0] in_real_2;
  logic [DATA_W-1:0] in_real_3;
  logic [DATA_W-1:0] in_im_0;
  logic [DATA_W-1:0] in_im_1;
  logic [DATA_W-1:0] in_im_2;
  logic [DATA_W-1:0] in_im_3;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_im;
  logic [3:0]        out_index;
  logic              out_last;
  logic              overflow;

  modport slave (
    input  in_valid, in_sof,
    input  in_real_0, in_real_1, in_real_2, in_real_3,
    input  in_im_0, in_im_1, in_im_2, in_im_3,
    input  out_ready,
    output out_valid, out_real, out_im, out_index, out_last, overflow
  );

  modport master (
    output in_valid, in_sof,
    output in_real_0, in_real_1, in_real_2, in_real_3,
    output in_im_0, in_im_1, in_im_2, in_im_3,
    output out_ready,
    input  out_valid, out_real, out_im, out_index, out_last, overflow
  );
endinterface

// File: rtl/fft_output_reorder.sv
// fft_output_reorder
//   Collects the four digit-reversed lanes of a radix-4 16-point FFT into a
//   ping-pong store (banks A/B, 16 complex words each) and streams each frame
//   out serially in natural bin order 0..15.
//   Lane k of group g carries bin g+4k, so it is written at address {k,g}.
//   Ports:
//     clk         - rising-edge clock
//     reset       - asynchronous active-low reset
//     bus         - group input / bin output / overflow (slave modport)
//     dbg_state_o - read state machine state (0 = IDLE, 1 = STREAM)
module fft_output_reorder #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  fft_output_reorder_if.slave bus,
  output logic                dbg_state_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  // Bank storage, index [bank][bin]
  logic [DATA_W-1:0] mem_re [2][16];
  logic [DATA_W-1:0] mem_im [2][16];

  // Write side
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] g_q, g_d;
  logic       overflow_q, overflow_d;

  // Read side
  rd_state_e         state_q;
  logic              rd_ptr_q;
  logic [3:0]        rd_idx_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_real_q;
  logic [DATA_W-1:0] out_im_q;

  logic       rd_free;
  logic       wr_bank_full;
  logic       wr_en;
  logic       wr_done;
  logic [1:0] wr_grp;
  logic [3:0] rd_next_idx;
  logic       rd_other;

  // Bin 15 is being accepted on this edge: the read bank becomes free.
  assign rd_free = (state_q == ST_STREAM) && bus.out_ready && (rd_idx_q == 4'd15);

  // A bank freed on this edge already counts as free for a write on the same edge.
  assign wr_bank_full = full_q[wr_ptr_q] && !(rd_free && (rd_ptr_q == wr_ptr_q));

  // in_sof restarts the frame at group 0, discarding any partial frame.
  assign wr_grp      = bus.in_sof ? 2'd0 : g_q;
  assign wr_en       = bus.in_valid && !wr_bank_full;
  assign wr_done     = wr_en && (wr_grp == 2'd3);
  assign rd_next_idx = rd_idx_q + 4'd1;
  assign rd_other    = ~rd_ptr_q;

  always_comb begin
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    g_d        = g_q;
    overflow_d = overflow_q;
    if (rd_free) begin
      full_d[rd_ptr_q] = 1'b0;
    end
    if (bus.in_valid) begin
      if (wr_bank_full) begin
        overflow_d = 1'b1;
        g_d        = wr_grp;
      end else if (wr_done) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        g_d              = 2'd0;
      end else begin
        g_d = wr_grp + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      g_q        <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      g_q        <= g_d;
      overflow_q <= overflow_d;
    end
  end

  // Bank contents carry no reset; only the full flags say what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_ptr_q][{2'd0, wr_grp}] <= bus.in_real_0;
      mem_re[wr_ptr_q][{2'd1, wr_grp}] <= bus.in_real_1;
      mem_re[wr_ptr_q][{2'd2, wr_grp}] <= bus.in_real_2;
      mem_re[wr_ptr_q][{2'd3, wr_grp}] <= bus.in_real_3;
      mem_im[wr_ptr_q][{2'd0, wr_grp}] <= bus.in_im_0;
      mem_im[wr_ptr_q][{2'd1, wr_grp}] <= bus.in_im_1;
      mem_im[wr_ptr_q][{2'd2, wr_grp}] <= bus.in_im_2;
      mem_im[wr_ptr_q][{2'd3, wr_grp}] <= bus.in_im_3;
    end
  end

  // Read state machine with registered outputs. The payload registers only
  // load on entry to STREAM or on a handshake, so they hold during stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= 1'b0;
      rd_idx_q    <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_im_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_ptr_q]) begin
            state_q     <= ST_STREAM;
            rd_idx_q    <= 4'd0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_real_q  <= mem_re[rd_ptr_q][0];
            out_im_q    <= mem_im[rd_ptr_q][0];
          end
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (rd_idx_q == 4'd15) begin
              rd_ptr_q   <= rd_other;
              rd_idx_q   <= 4'd0;
              out_last_q <= 1'b0;
              // Chain straight into the other bank when it is already full.
              if (full_q[rd_other]) begin
                out_real_q <= mem_re[rd_other][0];
                out_im_q   <= mem_im[rd_other][0];
              end else begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              rd_idx_q   <= rd_next_idx;
              out_last_q <= (rd_next_idx == 4'd15);
              out_real_q <= mem_re[rd_ptr_q][rd_next_idx];
              out_im_q   <= mem_im[rd_ptr_q][rd_next_idx];
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_index = rd_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
  assign dbg_state_o   = state_q;

endmodule
